// File: rtl/single_port_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle registered read) between
// requesters A and B, with a bounded burst so a busy requester cannot starve the other.
module single_port_ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  gnt_a,
  output logic                  rvalid_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  gnt_b,
  output logic                  rvalid_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  // Handshake: a requester holds req/we/addr/wdata until it sees gnt in the same
  // cycle; each gnt cycle issues exactly one RAM access. Reads return on rvalid
  // exactly one cycle after their grant. There is no backpressure on rvalid.

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  logic [1:0]       owner;
  logic             last_b;
  logic [CNT_W-1:0] cnt;
  logic             rv_a;
  logic             rv_b;
  logic             pick_a;
  logic             pick_b;
  logic             under_limit;

  assign under_limit = (cnt < BURST_LIMIT);

  // Priority ladder: owner keeps the grant until its burst runs out while the
  // other side waits; a fresh tie after an idle cycle goes to the side not served last.
  always_comb begin
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (owner == OWN_A && req_a && (under_limit || !req_b)) begin
      pick_a = 1'b1;
    end else if (owner == OWN_B && req_b && (under_limit || !req_a)) begin
      pick_b = 1'b1;
    end else if (owner == OWN_A && req_b) begin
      pick_b = 1'b1;
    end else if (owner == OWN_B && req_a) begin
      pick_a = 1'b1;
    end else if (req_a && req_b) begin
      pick_a = last_b;
      pick_b = !last_b;
    end else if (req_a) begin
      pick_a = 1'b1;
    end else if (req_b) begin
      pick_b = 1'b1;
    end
  end

  // Grants are suppressed while reset is asserted so nothing reaches the RAM.
  assign gnt_a = pick_a & ~rst;
  assign gnt_b = pick_b & ~rst;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_data = '0;
    if (gnt_a) begin
      ram_we   = we_a;
      ram_addr = addr_a;
      ram_data = wdata_a;
    end else if (gnt_b) begin
      ram_we   = we_b;
      ram_addr = addr_b;
      ram_data = wdata_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner  <= OWN_NONE;
      last_b <= 1'b1;
      cnt    <= '0;
      rv_a   <= 1'b0;
      rv_b   <= 1'b0;
    end else begin
      rv_a <= gnt_a & ~we_a;
      rv_b <= gnt_b & ~we_b;
      if (gnt_a || gnt_b) begin
        last_b <= gnt_b;
        if ((gnt_a && owner == OWN_A) || (gnt_b && owner == OWN_B)) begin
          if (under_limit) begin
            cnt <= cnt + CNT_ONE;
          end
        end else begin
          owner <= gnt_a ? OWN_A : OWN_B;
          cnt   <= CNT_ONE;
        end
      end else begin
        owner <= OWN_NONE;
        cnt   <= '0;
      end
    end
  end

  assign rvalid_a = rv_a;
  assign rvalid_b = rv_b;
  assign rdata_a  = ram_q;
  assign rdata_b  = ram_q;

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// Bench for single_port_ram_arbiter: behavioural RAM, directed grant sequences,
// and a read-data scoreboard fed from a shadow copy of the RAM contents.
module tb_single_port_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [5:0] addr_a = '0, addr_b = '0;
  logic [7:0] wdata_a = '0, wdata_b = '0;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we;
  logic [7:0] rdata_a, rdata_b, ram_data;
  logic [5:0] ram_addr;
  logic [7:0] ram_q = '0;

  logic [7:0] mem    [64] = '{default: '0};
  logic [7:0] shadow [64] = '{default: '0};
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic       pend_a = 1'b0, pend_b = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  single_port_ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Single-port RAM: registered read, read-before-write
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: pushes expected read data at grant, pops on rvalid
  always @(negedge clk) begin
    if (rst) begin
      check("rst_gnt_a", gnt_a, 0);
      check("rst_gnt_b", gnt_b, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_data", ram_data, 0);
      check("rst_rvalid_a", rvalid_a, 0);
      check("rst_rvalid_b", rvalid_b, 0);
      pend_a = 1'b0;
      pend_b = 1'b0;
      exp_q_a.delete();
      exp_q_b.delete();
    end else begin
      check("rvalid_a", rvalid_a, pend_a);
      if (pend_a && exp_q_a.size() > 0) check("rdata_a", rdata_a, exp_q_a.pop_front());
      check("rvalid_b", rvalid_b, pend_b);
      if (pend_b && exp_q_b.size() > 0) check("rdata_b", rdata_b, exp_q_b.pop_front());
      check("gnt_overlap", gnt_a & gnt_b, 0);
      if (gnt_a) begin
        check("ram_addr_a", ram_addr, addr_a);
        check("ram_we_a", ram_we, we_a);
        if (we_a) begin
          check("ram_data_a", ram_data, wdata_a);
          shadow[addr_a] = wdata_a;
        end else exp_q_a.push_back(shadow[addr_a]);
      end else if (gnt_b) begin
        check("ram_addr_b", ram_addr, addr_b);
        check("ram_we_b", ram_we, we_b);
        if (we_b) begin
          check("ram_data_b", ram_data, wdata_b);
          shadow[addr_b] = wdata_b;
        end else exp_q_b.push_back(shadow[addr_b]);
      end else begin
        check("idle_ram_we", ram_we, 0);
        check("idle_ram_addr", ram_addr, 0);
      end
      pend_a = gnt_a & ~we_a;
      pend_b = gnt_b & ~we_b;
    end
  end

  // Driver tasks
  task automatic drive(input logic ra, wa, input logic [5:0] aa, input logic [7:0] da,
                       input logic rb, wb, input logic [5:0] ab, input logic [7:0] db);
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
  endtask

  task automatic apply(input logic ra, wa, input logic [5:0] aa, input logic [7:0] da,
                       input logic rb, wb, input logic [5:0] ab, input logic [7:0] db,
                       input logic ega, egb, input string tag);
    @(posedge clk); #1;
    drive(ra, wa, aa, da, rb, wb, ab, db);
    @(negedge clk);
    check({tag, "_gnt_a"}, gnt_a, ega);
    check({tag, "_gnt_b"}, gnt_b, egb);
  endtask

  task automatic idle(input string tag);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1, 1, 6'h2A, 8'h77, 1, 0, 6'h15, 8'h33);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [5:0] a;
    logic [7:0] d;
    do_reset();

    // A write then read of the same address
    apply(1, 1, 6'd3, 8'hA5, 0, 0, 0, 0, 1, 0, "a_wr3");
    apply(1, 0, 6'd3, 8'h00, 0, 0, 0, 0, 1, 0, "a_rd3");
    idle("after_rd3");
    check("rd3_rvalid_a", rvalid_a, 1);
    check("rd3_rdata_a", rdata_a, 8'hA5);
    check("rd3_rvalid_b", rvalid_b, 0);

    // Idle cycle left owner NONE with last=A: tie goes to B
    apply(1, 0, 6'd3, 0, 1, 0, 6'd3, 0, 0, 1, "tie_last_a");
    idle("after_tie");

    // Sustained contention from the first cycle after reset
    do_reset();
    for (int i = 0; i < 14; i++) begin
      apply(1, 1, 6'd10, 8'h5C, 1, 0, 6'd10, 0, ((i / 4) % 2) == 0, ((i / 4) % 2) == 1, "contend");
    end
    idle("after_contend");

    // A alone for 10 cycles, then B arrives while A still requests
    for (int i = 0; i < 10; i++) begin
      a = 6'($urandom_range(0, 63));
      apply(1, 0, a, 0, 0, 0, 0, 0, 1, 0, "a_alone");
    end
    apply(1, 0, 6'd4, 0, 1, 0, 6'd5, 0, 0, 1, "b_after_sat");
    idle("after_sat");

    // Preload addrs 0..2 through A, then B reads them back-to-back
    for (int i = 0; i < 3; i++) begin
      d = 8'h30 + 8'(i);
      apply(1, 1, 6'(i), d, 0, 0, 0, 0, 1, 0, "a_preload");
    end
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, 0, 1, 0, 6'(i), 0, 0, 1, "b_burst_rd");
      if (i > 0) begin
        check("burst_rvalid_b", rvalid_b, 1);
        check("burst_rdata_b", rdata_b, 8'h30 + 8'(i - 1));
      end
    end
    idle("after_burst");
    check("burst_last_rvalid_b", rvalid_b, 1);
    check("burst_last_rdata_b", rdata_b, 8'h32);
    idle("burst_drain");
    check("burst_drained_rvalid_b", rvalid_b, 0);

    // Reset in the cycle after a read grant clears rvalid at once
    apply(1, 0, 6'd1, 0, 1, 0, 6'd1, 0, 1, 0, "pre_rst_rd");
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_clears_rvalid_a", rvalid_a, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 0, 6'd2, 0, 1, 0, 6'd0, 0);
    @(negedge clk);
    check("post_rst_gnt_a", gnt_a, 1);
    check("post_rst_gnt_b", gnt_b, 0);
    idle("post_rst_drain");
    check("post_rst_rdata_a", rdata_a, 8'h32);
    idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/single_port_ram_arbiter.md
Name: single_port_ram_arbiter

Overview:
- Shares one single-port RAM (1-cycle registered read, read-before-write on the same address) between two requesters, A and B.
- Example pairing: A is the weight/feature loader, B is the convolution engine.
- Grants at most one access per cycle, with round-robin priority and a bounded burst so neither side starves.
- Sits directly in front of the RAM instance: it drives the RAM data/addr/we pins and routes q back to the requester that issued the read.

Parameters:
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 6, RAM address width (depth 2**ADDR_WIDTH).
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is waiting; legal range >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_a  in  1  A requests one access this cycle.
- we_a  in  1  A access is a write (1) or a read (0).
- addr_a  in  ADDR_WIDTH  A address.
- wdata_a  in  DATA_WIDTH  A write data.
- gnt_a  out  1  A's access is issued to the RAM this cycle.
- rvalid_a  out  1  rdata_a holds A's read result.
- rdata_a  out  DATA_WIDTH  read data for A.
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as the A ports, for requester B.
- ram_data  out  DATA_WIDTH  to RAM data.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_we  out  1  to RAM we.
- ram_q  in  DATA_WIDTH  from RAM q.

Behaviour:
- State:
  - owner ∈ {NONE, A, B}.
  - last ∈ {A, B}: the last requester granted.
  - cnt: consecutive grants to owner, width $clog2(MAX_BURST+1).
  - rv_a, rv_b: registered read-valid flags.
- Reset values: owner=NONE, last=B (so A wins the first tie), cnt=0, rv_a=rv_b=0. Reset takes effect immediately, mid-operation or not.
- Outputs during reset: gnt_a=gnt_b=0, ram_we=0, ram_addr=0, ram_data=0, rvalid_a=rvalid_b=0.
- Grant decision is combinational, from the current state plus req_a/req_b:
  - Owner still requesting, and (cnt < MAX_BURST or other side idle): owner keeps the grant.
  - Else, the other side requesting: grant the other side.
  - Else, owner NONE and both requesting: grant the side != last.
  - Else, exactly one side requesting: grant that side.
  - Else: no grant.
- gnt_a and gnt_b are never both 1.
- A request is accepted only in a cycle with gnt_x=1. A requester must hold req/we/addr/wdata until it sees gnt. Each gnt cycle is exactly one access. Deasserting req without a grant is legal; nothing is issued.
- RAM drive:
  - In a grant cycle, ram_addr/ram_data/ram_we = the granted side's addr/wdata/we.
  - With no grant, ram_we=0 and ram_addr/ram_data hold 0.
- State update on the clock edge:
  - Grant to the same side as owner: cnt = min(cnt+1, MAX_BURST).
  - Grant to a different side, or owner NONE: owner = granted side, cnt = 1.
  - Any grant: last = granted side.
  - No grant: owner=NONE, cnt=0; last unchanged.
- Read return:
  - rv_x <= gnt_x & ~we_x.
  - rvalid_x = rv_x.
  - rdata_a = rdata_b = ram_q, qualified only by rvalid.
  - Read latency is exactly 1 cycle after the grant cycle; back-to-back reads give rvalid every cycle.
- Writes produce no rvalid. Write and read to the same address in consecutive grants: the read returns the new data. A write's own RAM q output (old data) is ignored.
- MAX_BURST=1: strict alternation whenever both sides request.
- Sustained contention: each side receives exactly MAX_BURST consecutive grants, then yields.

Test Plan:
- Reset, then A writes 0xA5 to addr 3, then reads addr 3 -> gnt_a in both cycles; rvalid_a=1 with rdata_a=0xA5 exactly one cycle after the read grant; rvalid_b stays 0.
- Both request continuously from the first cycle after reset, MAX_BURST=4 -> grants go A,A,A,A,B,B,B,B,A…; gnt_a and gnt_b never overlap.
- A requests continuously, B idle, for 10 cycles -> A granted all 10 cycles (cnt saturates at 4). Then B raises req -> B granted on the next cycle.
- Owner NONE (idle cycle), last=A, both raise req together -> B granted first.
- B issues reads to addrs 0,1,2 back-to-back -> rvalid_b high for 3 consecutive cycles, each lagging its grant by 1, data in address order.
- Assert rst in the cycle after a read grant -> rvalid cleared immediately. After release, owner=NONE; a simultaneous A/B request grants A.
